// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: EX-stage control bundle, ALU compare opcodes and
// the payload carried through the EX/MEM skid buffer.
package mips_pkg;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       br_eq;
    logic       br_ne;
    logic       br_fpt;
    logic       br_fpf;
  } ex_ctrl_t;

  localparam logic [3:0] ALU_CEQS = 4'b1110;
  localparam logic [3:0] ALU_CLTS = 4'b1111;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    ex_ctrl_t    ctrl;
    logic [31:0] target;
    logic        taken;
  } ex_entry_t;

  localparam int EX_ENTRY_W = $bits(ex_entry_t);

  function automatic logic is_fp_cmp(input logic [3:0] op);
    return (op == ALU_CEQS) || (op == ALU_CLTS);
  endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Two-entry skid buffer (main + skid) with a generic payload. in_ready depends
// only on the skid flop, so out_ready never reaches the upstream handshake.
module ex_mem_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, drain;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign drain     = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: no accept possible, a drain promotes the skid entry.
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves branches and tracks the FP condition flag
// at acceptance, then holds the entry in a two-deep skid buffer.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter logic FCC_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_alu_control,
  input  logic [31:0] in_result,
  input  logic        in_zero,
  input  logic        in_fp_cmp,
  input  logic [31:0] in_store_data,
  input  logic [11:0] in_ctrl,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [11:0] out_ctrl,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        fcc
);

  ex_ctrl_t                ctrl_in;
  ex_entry_t               in_entry, out_entry;
  logic [EX_ENTRY_W-1:0]   out_bits;
  logic                    fcc_q, fcc_d;
  logic                    accept;

  assign ctrl_in = ex_ctrl_t'(in_ctrl);
  assign accept  = in_valid & in_ready & ~flush;

  // Branch uses the flag as it stood before this instruction; a compare
  // accepted now only affects later instructions.
  always_comb begin
    in_entry.result     = in_result;
    in_entry.store_data = in_store_data;
    in_entry.ctrl       = ctrl_in;
    in_entry.target     = in_target;
    in_entry.taken      = (ctrl_in.br_eq  &  in_zero) |
                          (ctrl_in.br_ne  & ~in_zero) |
                          (ctrl_in.br_fpt &  fcc_q)   |
                          (ctrl_in.br_fpf & ~fcc_q);
    fcc_d = fcc_q;
    if (accept && is_fp_cmp(in_alu_control)) fcc_d = in_fp_cmp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcc_q <= FCC_INIT;
    else        fcc_q <= fcc_d;
  end

  ex_mem_skid #(.WIDTH(EX_ENTRY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid & ~flush),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bits)
  );

  assign out_entry      = ex_entry_t'(out_bits);
  assign out_result     = out_entry.result;
  assign out_store_data = out_entry.store_data;
  assign out_ctrl       = out_entry.ctrl;
  assign branch_target  = out_entry.target;
  assign branch_taken   = out_valid & out_entry.taken;
  assign fcc            = fcc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver models acceptance and FCC,
// the monitor compares every presented output against the expected queue.
module tb_ex_mem_stage;
  import mips_pkg::*;

  localparam logic TB_FCC = 1'b1;

  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_zero = 1'b0, in_fp_cmp = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_alu_control = '0;
  logic [31:0] in_result = '0, in_store_data = '0, in_target = '0;
  logic [11:0] in_ctrl = '0;
  logic        in_ready, out_valid, branch_taken, fcc;
  logic [31:0] out_result, out_store_data, branch_target;
  logic [11:0] out_ctrl;

  typedef struct {
    logic [31:0] res, sd, tgt;
    logic [11:0] ctrl;
    logic        tk;
  } exp_t;

  exp_t exp_q[$];
  logic mfcc;
  int   checks = 0, errors = 0;
  bit   mon_en = 0;

  ex_mem_stage #(.FCC_INIT(TB_FCC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_control(in_alu_control), .in_result(in_result), .in_zero(in_zero),
    .in_fp_cmp(in_fp_cmp), .in_store_data(in_store_data), .in_ctrl(in_ctrl),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_ctrl(out_ctrl),
    .branch_taken(branch_taken), .branch_target(branch_target), .fcc(fcc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ctl(input int kind);
    ex_ctrl_t c;
    c = '0;
    c.rd = 5'd3;
    case (kind)
      1: c.br_eq  = 1'b1;
      2: c.br_ne  = 1'b1;
      3: c.br_fpt = 1'b1;
      4: c.br_fpf = 1'b1;
      default: c.reg_write = 1'b1;
    endcase
    return c;
  endfunction

  // One cycle of stimulus; the model decides acceptance from its own occupancy.
  task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic [3:0] op,
                     input logic [31:0] res, input logic [31:0] sd, input logic [31:0] tgt,
                     input logic z, input logic fp, input logic [11:0] c);
    exp_t     e;
    ex_ctrl_t cc;
    logic     acc;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl; in_alu_control = op;
    in_result = res; in_store_data = sd; in_target = tgt; in_zero = z;
    in_fp_cmp = fp; in_ctrl = c;
    #1;
    cc    = ex_ctrl_t'(c);
    acc   = iv && !fl && (exp_q.size() < 2);
    e.res = res; e.sd = sd; e.tgt = tgt; e.ctrl = c;
    e.tk  = (cc.br_eq && z) || (cc.br_ne && !z) || (cc.br_fpt && mfcc) || (cc.br_fpf && !mfcc);
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    if (acc) begin
      exp_q.push_back(e);
      if (op == 4'b1110 || op == 4'b1111) mfcc = fp;
    end
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, ordy, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 12'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && mon_en) begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
        chk("fcc",       32'(fcc),       32'(mfcc));
        if (out_valid && exp_q.size() > 0) begin
          chk("out_result",     out_result,         exp_q[0].res);
          chk("out_store_data", out_store_data,     exp_q[0].sd);
          chk("out_ctrl",       32'(out_ctrl),      32'(exp_q[0].ctrl));
          chk("branch_target",  branch_target,      exp_q[0].tgt);
          chk("branch_taken",   32'(branch_taken),  32'(exp_q[0].tk));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    mfcc = TB_FCC;
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid",    32'(out_valid),    32'h0);
    chk("rst in_ready",     32'(in_ready),     32'h1);
    chk("rst fcc",          32'(fcc),          32'(TB_FCC));
    chk("rst branch_taken", 32'(branch_taken), 32'h0);
    chk("rst out_result",   out_result,        32'h0);
    chk("rst target",       branch_target,     32'h0);
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1;

    // single add, 1-cycle latency
    cyc(1, 1, 0, 4'h2, 32'h0000_0005, 32'h0, 32'h0, 0, 0, ctl(0));
    idle(1); idle(1);

    // back-to-back with stalled output, then release
    cyc(1, 0, 0, 4'h2, 32'h11, 32'hA1, 32'h0, 0, 0, ctl(0));
    cyc(1, 0, 0, 4'h2, 32'h22, 32'hA2, 32'h0, 0, 0, ctl(0));
    cyc(1, 0, 0, 4'h2, 32'h33, 32'hA3, 32'h0, 0, 0, ctl(0));
    idle(0);
    cyc(1, 1, 0, 4'h2, 32'h33, 32'hA3, 32'h0, 0, 0, ctl(0));
    repeat (3) idle(1);

    // compare then FP branches
    cyc(1, 1, 0, ALU_CLTS, 32'h0, 32'h0, 32'h0, 0, 1, ctl(0));
    cyc(1, 1, 0, 4'h6, 32'h0, 32'h0, 32'h0040_0100, 0, 0, ctl(3));
    idle(1);
    chk("fcc after c.lt.s", 32'(fcc), 32'h1);
    cyc(1, 1, 0, ALU_CLTS, 32'h0, 32'h0, 32'h0, 0, 1, ctl(0));
    cyc(1, 1, 0, 4'h6, 32'h0, 32'h0, 32'h0040_0200, 0, 0, ctl(4));
    idle(1);

    // beq / bne with zero set
    cyc(1, 1, 0, 4'h6, 32'h0, 32'h0, 32'h0040_0020, 1, 0, ctl(1));
    cyc(1, 1, 0, 4'h6, 32'h0, 32'h0, 32'h0040_0020, 1, 0, ctl(2));
    idle(1); idle(1);

    // flush with both entries full and a compare presented
    cyc(1, 0, 0, 4'h2, 32'h44, 32'h0, 32'h0, 0, 0, ctl(0));
    cyc(1, 0, 0, 4'h2, 32'h55, 32'h0, 32'h0, 0, 0, ctl(0));
    cyc(1, 0, 1, ALU_CEQS, 32'h0, 32'h0, 32'h0, 0, ~mfcc, ctl(0));
    idle(1);
    chk("fcc kept on flush", 32'(fcc), 32'h1);

    // move fcc away from its reset value, fill, then reset mid-stream
    cyc(1, 1, 0, ALU_CEQS, 32'h0, 32'h0, 32'h0, 0, 0, ctl(0));
    idle(1);
    cyc(1, 0, 0, 4'h2, 32'h66, 32'h0, 32'h0, 0, 0, ctl(0));
    cyc(1, 0, 0, 4'h2, 32'h77, 32'h0, 32'h0, 0, 0, ctl(0));
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre-reset fcc", 32'(fcc), 32'h0);
    @(negedge clk);
    #3 rst_n = 1'b0; mon_en = 0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'h0);
    chk("mid rst in_ready",  32'(in_ready),  32'h1);
    chk("mid rst fcc",       32'(fcc),       32'(TB_FCC));
    exp_q.delete();
    mfcc = TB_FCC;
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1;

    // randomized traffic
    repeat (1500) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? {3'b111, 1'($urandom)} : 4'($urandom);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
          op, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 12'($urandom));
    end
    repeat (4) idle(1);
    chk("drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter FCC_INIT, default 1'b0, reset value of the FP condition flag.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  synchronous kill of all held entries.
REQ-005 in_valid  in  1  ALU stage presents an instruction.
REQ-006 in_ready  out  1  stage can accept; registered (skid entry empty).
REQ-007 in_alu_control  in  4  ALU opcode of the presented instruction.
REQ-008 in_result  in  32  ALU result.
REQ-009 in_zero  in  1  ALU zero flag.
REQ-010 in_fp_cmp  in  1  ALU FP compare result (valid for opcodes 1110/1111).
REQ-011 in_store_data  in  32  rt value for stores.
REQ-012 in_ctrl  in  12  ex_ctrl_t: rd[4:0], reg_write, mem_read, mem_write, br_eq, br_ne, br_fpt, br_fpf.
REQ-013 in_target  in  32  branch target address.
REQ-014 out_valid  out  1  MEM stage entry valid.
REQ-015 out_ready  in  1  MEM stage accepts.
REQ-016 out_result, out_store_data  out  32 each  held ALU result and store data.
REQ-017 out_ctrl  out  12  held ex_ctrl_t.
REQ-018 branch_taken  out  1  resolved branch decision of the output entry (qualified by out_valid).
REQ-019 branch_target  out  32  held target of the output entry.
REQ-020 fcc  out  1  architectural FP condition flag.

Function
REQ-021 Stage SHALL be a two-entry skid buffer (main, skid); input accepted when in_valid && in_ready; output transfers when out_valid && out_ready.
REQ-022 Latency in->out SHALL be exactly 1 cycle when the buffer is empty; ordering strictly FIFO.
REQ-023 in_ready SHALL equal !skid_valid, driven from a flop; no combinational path from out_ready to in_ready.
REQ-024 Acceptance with main empty, or main draining the same cycle, SHALL load main; with main held (out_ready=0) SHALL load skid; on drain, skid SHALL move to main next cycle.
REQ-025 Output signals SHALL remain stable while out_valid && !out_ready.
REQ-026 branch_taken SHALL be computed at acceptance: br_eq&zero | br_ne&!zero | br_fpt&fcc_eff | br_fpf&!fcc_eff; stored with the entry.
REQ-027 fcc_eff SHALL be the fcc register value at acceptance; fcc updates to in_fp_cmp on acceptance of opcode 1110 or 1111, visible to the next accepted instruction.
REQ-028 Compare opcodes SHALL still enter the buffer (reg_write as supplied) so ordering is preserved.
REQ-029 flush SHALL clear main_valid, skid_valid and assert in_ready next cycle; input presented in the flush cycle SHALL be dropped and SHALL NOT update fcc.
REQ-030 flush SHALL NOT revert fcc updates accepted in earlier cycles.
REQ-031 Simultaneous accept and drain with both entries full SHALL not occur (in_ready=0); accept and drain with one entry SHALL keep occupancy 1.

Reset
REQ-032 rst_n low SHALL immediately clear main_valid, skid_valid, set in_ready=1, out_valid=0, branch_taken=0, fcc=FCC_INIT; data/target regs reset to 0.
REQ-033 Reset mid-operation SHALL discard all entries; first accept allowed on the first edge after rst_n deasserts.

Structure
REQ-034 ex_ctrl_t (packed, 12 bits) and ALU opcode constants ALU_CEQS=4'b1110, ALU_CLTS=4'b1111 SHALL live in shared package mips_pkg.
REQ-035 Skid storage SHALL be one sub-module ex_mem_skid (generic width payload, valid/ready both sides); branch/fcc logic stays in ex_mem_stage.

Verification
REQ-036 Single add, result 0x0000_0005, out_ready=1 -> out_valid one cycle later, out_result=0x5, in_ready stays 1.
REQ-037 Three back-to-back accepts, out_ready=0 two cycles -> in_ready drops after second accept, third held off; release -> outputs in order, none lost.
REQ-038 C.LT.S with in_fp_cmp=1, then bc1t -> fcc=1, bc1t entry branch_taken=1; bc1f same sequence -> 0.
REQ-039 beq with in_zero=1, target 0x0040_0020 -> branch_taken=1, branch_target=0x0040_0020; bne same -> 0.
REQ-040 flush with both entries full and a C.EQ.S (in_fp_cmp=1) presented -> out_valid=0 next cycle, in_ready=1, fcc unchanged.
REQ-041 rst_n asserted mid-stream with skid full -> out_valid=0, in_ready=1, fcc=FCC_INIT asynchronously.
